bypass_dp_ram: RTL and testbench
================================

BYPASS_DP_RAM -- requirements
Module: bypass_dp_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of BYTE_WIDTH.
REQ-002 Parameter DEPTH, default 128: number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter BYTE_WIDTH, default 8: bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH; AW = log2(DEPTH).
REQ-004 Parameter LATENCY, default 1: read latency in cycles; legal values are 1 and 2 only.
REQ-005 Parameter CLEAR_ON_RESET, default 1: 1 = zero every entry after reset; 0 = no clear.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 ena  input  1  write port enable.
REQ-009 wea  input  NB  per-byte write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-010 addra  input  AW  write address.
REQ-011 dina  input  DATA_WIDTH  write data.
REQ-012 enb  input  1  read request.
REQ-013 addrb  input  AW  read address.
REQ-014 doutb  output  DATA_WIDTH  read data.
REQ-015 rvalidb  output  1  one-cycle pulse; doutb holds the data for an accepted read.
REQ-016 busy  output  1  high while reset or clear is in progress; all requests are ignored while high.

Function
REQ-017 A write SHALL be accepted when ena=1, wea!=0 and busy=0; only lanes with wea[i]=1 are updated at the clock edge.
REQ-018 A read SHALL be accepted when enb=1 and busy=0; rvalidb=1 and doutb valid exactly LATENCY cycles later.
REQ-019 Same-cycle collision (accepted read and write, addrb==addra): the returned data SHALL be the merged word (new bytes for enabled lanes, old bytes otherwise); write-first.
REQ-020 A read accepted the cycle after a write to the same address SHALL return the written data, with no stall.
REQ-021 The bypass SHALL cover any write that lands before the read data is captured, for both LATENCY values.
REQ-022 doutb SHALL hold its last value when no read completes; rvalidb=0 in those cycles.
REQ-023 LATENCY=2 SHALL add one output register stage after the array read; reads are fully pipelined (one per cycle).
REQ-024 Clear FSM states: CLEAR, READY.
REQ-025 Reset SHALL enter CLEAR when CLEAR_ON_RESET=1, and READY otherwise.
REQ-026 CLEAR SHALL write zero to address cnt, cnt = 0..DEPTH-1, one per cycle, then go to READY after writing DEPTH-1.
REQ-027 busy SHALL be 1 in CLEAR and 0 in READY; clear duration is exactly DEPTH cycles after rst deasserts.
REQ-028 Reads in flight when busy rises SHALL be dropped: no rvalidb pulse.
REQ-029 Address arithmetic SHALL be AW bits; the clear counter SHALL be AW+1 bits so the terminal count is detected without wrap.

Reset
REQ-030 During rst=1: doutb=0, rvalidb=0, busy=1, read pipeline flushed, clear counter=0.
REQ-031 rst asserted mid-clear SHALL restart the clear from address 0.
REQ-032 rst SHALL NOT alter array contents itself (only the clear FSM does).
REQ-033 With CLEAR_ON_RESET=0, busy=0 on the first cycle after rst deasserts.

Structure
REQ-034 FSM state encoding and the LATENCY legality check SHALL live in the shared package ram_pkg.
REQ-035 Storage SHALL be one sub-module, sdp_ram_core: inferred simple dual-port array with byte-write and a registered read.
REQ-036 The sub-module SHALL have no reset; bypass, merge, the clear FSM and the output pipeline stay in bypass_dp_ram.

Verification
REQ-037 DEPTH=16, CLEAR_ON_RESET=1, release rst -> busy high exactly 16 cycles; then reads of addresses 0..15 all return 0.
REQ-038 Write 0xAABBCCDD to address 5, wea=4'b1111, then write 0x11223344 to address 5 with wea=4'b0101 -> read of address 5 returns 0xAA22CC44.
REQ-039 Same cycle: write 0xDEADBEEF to address 3 and read address 3, for LATENCY=1 and for LATENCY=2 -> doutb=0xDEADBEEF with rvalidb at cycle 1 and cycle 2 respectively.
REQ-040 Back-to-back reads on addresses 0,1,2 in consecutive cycles, LATENCY=2 -> three consecutive rvalidb pulses, data in order, no bubbles.
REQ-041 Assert rst at clear cycle 7 of 16 -> busy stays high; clear restarts and busy falls 16 cycles after the second rst release.
REQ-042 Assert ena/enb while busy=1 -> no array change and no rvalidb.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the bypassing dual-port RAM: clear FSM encoding and
// the legality check for the read latency parameter.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Simple dual-port storage array: byte-lane write port plus a registered
// read port. No reset, so it maps onto block RAM.
module sdp_ram_core #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 128,
    parameter  int BYTE_WIDTH = 8,
    localparam int NB         = DATA_WIDTH / BYTE_WIDTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [NB-1:0]         we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Read-before-write on a same-address collision; the wrapper patches it.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/bypass_dp_ram.sv
// Dual-port RAM with write-to-read bypass, optional post-reset clear and a
// 1- or 2-cycle read pipeline. Storage lives in sdp_ram_core.
module bypass_dp_ram
    import ram_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int DEPTH          = 128,
    parameter  int BYTE_WIDTH     = 8,
    parameter  int LATENCY        = 1,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int NB             = DATA_WIDTH / BYTE_WIDTH,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NB-1:0]         wea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [AW-1:0]         addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  rvalidb,
    output logic                  busy
);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("bypass_dp_ram: LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("bypass_dp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    clr_state_t            state;
    logic [AW:0]           cnt;
    logic                  clr_wr, acc_w, acc_r;
    logic [DATA_WIDTH-1:0] wmask;
    logic [NB-1:0]         core_we;
    logic [AW-1:0]         core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata, core_rdata;

    logic [AW-1:0]         s1_addr;
    logic [DATA_WIDTH-1:0] byp_mask, byp_data, merged1, dout_q;
    logic [LATENCY:1]      vld_pipe;

    assign busy   = rst || (state == CLEAR);
    assign clr_wr = !rst && (state == CLEAR);
    assign acc_w  = ena && (|wea) && !busy;
    assign acc_r  = enb && !busy;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) wmask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wea[i]}};
    end

    // Clear FSM: one zero word per cycle, counter one bit wider than the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= READY;
        end
    end

    assign core_we    = clr_wr ? {NB{1'b1}} : (acc_w ? wea : '0);
    assign core_waddr = clr_wr ? cnt[AW-1:0] : addra;
    assign core_wdata = clr_wr ? '0 : dina;

    sdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (acc_r),
        .raddr (addrb),
        .rdata (core_rdata)
    );

    // Remember a same-cycle colliding write so its lanes override the stale array read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_addr  <= '0;
            byp_mask <= '0;
            byp_data <= '0;
            vld_pipe <= '0;
        end else begin
            if (acc_r) begin
                s1_addr  <= addrb;
                byp_mask <= (acc_w && addra == addrb) ? wmask : '0;
                byp_data <= dina;
            end
            vld_pipe[1] <= acc_r;
            for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign merged1 = (core_rdata & ~byp_mask) | (byp_data & byp_mask);
    assign rvalidb = vld_pipe[LATENCY];

    if (LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst)              dout_q <= '0;
            else if (vld_pipe[1]) dout_q <= merged1;
        end
        assign doutb = vld_pipe[1] ? merged1 : dout_q;
    end else begin : g_lat2
        logic                  hit2;
        logic [DATA_WIDTH-1:0] merged2;

        // A write landing while the read sits in stage 1 still wins.
        assign hit2    = acc_w && (addra == s1_addr);
        assign merged2 = hit2 ? ((merged1 & ~wmask) | (dina & wmask)) : merged1;

        always_ff @(posedge clk) begin
            if (rst)              dout_q <= '0;
            else if (vld_pipe[1]) dout_q <= merged2;
        end
        assign doutb = dout_q;
    end

endmodule

// File: tb/tb_bypass_dp_ram.sv
// Bench for bypass_dp_ram: LATENCY=1 and LATENCY=2 instances share stimulus;
// a behavioural memory model feeds per-instance scoreboards.
module tb_bypass_dp_ram;

    localparam int DW = 32, DEPTH = 16, NB = 4, AW = 4;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b0, enb = 1'b0;
    logic [NB-1:0] wea = '0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0;
    logic [DW-1:0] dout1, dout2;
    logic rv1, rv2, busy1, busy2;

    always #5 clk = ~clk;

    bypass_dp_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout1), .rvalidb(rv1), .busy(busy1));

    bypass_dp_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(8), .LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout2), .rvalidb(rv2), .busy(busy2));

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t           q1[$], q2[$];
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] last1 = '0, last2 = '0;
    int            m_clr = 0, cyc = 0, tests = 0, fails = 0;
    bit            started = 0;

    // Reference model: write-first, data frozen at the cycle the read completes.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_clr = DEPTH;
            q1.delete();
            q2.delete();
            last1 = '0;
            last2 = '0;
            started = 1;
        end else if (m_clr > 0) begin
            mem[DEPTH-m_clr] = '0;
            m_clr--;
        end else begin
            if (ena) for (int i = 0; i < NB; i++) if (wea[i]) mem[addra][i*8 +: 8] = dina[i*8 +: 8];
            if (enb) begin
                q1.push_back('{addrb, '0, cyc});
                q2.push_back('{addrb, '0, cyc + 1});
            end
        end
        foreach (q1[i]) if (q1[i].due == cyc) q1[i].data = mem[q1[i].addr];
        foreach (q2[i]) if (q2[i].due == cyc) q2[i].data = mem[q2[i].addr];
    end

    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (busy1 !== (rst || m_clr > 0) || busy2 !== (rst || m_clr > 0)) begin
                fails++;
                $display("FAIL busy cyc=%0d: got %b/%b expected %b", cyc, busy1, busy2, (rst || m_clr > 0));
            end
            tests++;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                if (rv1 !== 1'b1 || dout1 !== q1[0].data) begin
                    fails++;
                    $display("FAIL rd_l1 cyc=%0d addr=%0d: got rv=%b %h expected rv=1 %h", cyc, q1[0].addr, rv1, dout1, q1[0].data);
                end
                last1 = q1[0].data;
                void'(q1.pop_front());
            end else if (rv1 !== 1'b0 || dout1 !== last1) begin
                fails++;
                $display("FAIL idle_l1 cyc=%0d: got rv=%b %h expected rv=0 %h", cyc, rv1, dout1, last1);
            end
            tests++;
            if (q2.size() > 0 && q2[0].due == cyc) begin
                if (rv2 !== 1'b1 || dout2 !== q2[0].data) begin
                    fails++;
                    $display("FAIL rd_l2 cyc=%0d addr=%0d: got rv=%b %h expected rv=1 %h", cyc, q2[0].addr, rv2, dout2, q2[0].data);
                end
                last2 = q2[0].data;
                void'(q2.pop_front());
            end else if (rv2 !== 1'b0 || dout2 !== last2) begin
                fails++;
                $display("FAIL idle_l2 cyc=%0d: got rv=%b %h expected rv=0 %h", cyc, rv2, dout2, last2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic op(input logic we_en, input logic [NB-1:0] we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        ena = we_en; wea = we; addra = wa; dina = wd; enb = re; addrb = ra;
        step();
        ena = 1'b0; wea = '0; enb = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy1 && busy2) n++;
            else break;
        end
        tests++;
        if (n != DEPTH) begin
            fails++;
            $display("FAIL %s: busy cycles got %0d expected %0d", name, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        tests++;
        if (dout1 !== '0 || dout2 !== '0 || rv1 !== 1'b0 || rv2 !== 1'b0 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got %h %h rv=%b%b busy=%b%b expected 0 0 rv=00 busy=11",
                     dout1, dout2, rv1, rv2, busy1, busy2);
        end
        step();
        rst = 1'b0;
        count_busy("clear_len");
    endtask

    task automatic test_clear_readback();
        step();
        for (int a = 0; a < DEPTH; a++) op(0, '0, '0, '0, 1, AW'(a));
        idle(3);
    endtask

    task automatic test_byte_write();
        op(1, 4'hF, 4'd5, 32'hAABBCCDD, 0, '0);
        op(1, 4'b0101, 4'd5, 32'h11223344, 0, '0);
        op(0, '0, '0, '0, 1, 4'd5);
        @(negedge clk);
        tests++;
        if (dout1 !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL byte_write_l1: got %h expected aa22cc44", dout1);
        end
        @(negedge clk);
        tests++;
        if (dout2 !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL byte_write_l2: got %h expected aa22cc44", dout2);
        end
        idle(2);
    endtask

    task automatic test_collision();
        op(1, 4'hF, 4'd3, 32'hDEADBEEF, 1, 4'd3);
        @(negedge clk);
        tests++;
        if (rv1 !== 1'b1 || dout1 !== 32'hDEADBEEF || rv2 !== 1'b0) begin
            fails++;
            $display("FAIL collide_c1: got rv1=%b %h rv2=%b expected rv1=1 deadbeef rv2=0", rv1, dout1, rv2);
        end
        @(negedge clk);
        tests++;
        if (rv2 !== 1'b1 || dout2 !== 32'hDEADBEEF || rv1 !== 1'b0) begin
            fails++;
            $display("FAIL collide_c2: got rv2=%b %h rv1=%b expected rv2=1 deadbeef rv1=0", rv2, dout2, rv1);
        end
        idle(2);
        op(1, 4'b1010, 4'd3, 32'h01020304, 1, 4'd3);
        idle(3);
    endtask

    task automatic test_bypass_window();
        op(1, 4'hF, 4'd7, 32'h12345678, 0, '0);
        op(0, '0, '0, '0, 1, 4'd7);
        op(1, 4'b0011, 4'd7, 32'hFFFF9999, 0, '0);
        op(1, 4'hF, 4'd9, 32'h0BADF00D, 0, '0);
        op(0, '0, '0, '0, 1, 4'd9);
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v [3];
        v[0] = 32'h10101010; v[1] = 32'h20202020; v[2] = 32'h30303030;
        for (int i = 0; i < 3; i++) op(1, 4'hF, AW'(i), v[i], 0, '0);
        fork
            begin
                for (int i = 0; i < 3; i++) op(0, '0, '0, '0, 1, AW'(i));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    tests++;
                    if (rv2 !== 1'b1 || dout2 !== v[i]) begin
                        fails++;
                        $display("FAIL b2b_%0d: got rv=%b %h expected rv=1 %h", i, rv2, dout2, v[i]);
                    end
                end
                @(negedge clk);
                tests++;
                if (rv2 !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_end: got rv=%b expected 0", rv2);
                end
            end
        join
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++)
            op(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
        idle(3);
    endtask

    task automatic test_busy_ignore();
        rst = 1'b1;
        op(1, 4'hF, 4'd2, 32'h55555555, 1, 4'd2);
        rst = 1'b0;
        idle(8);
        for (int i = 0; i < 3; i++) op(1, 4'hF, 4'd2, 32'hCAFEF00D, 1, 4'd2);
        idle(8);
        op(0, '0, '0, '0, 1, 4'd2);
        @(negedge clk);
        tests++;
        if (rv1 !== 1'b1 || dout1 !== '0) begin
            fails++;
            $display("FAIL busy_ignore: got rv=%b %h expected rv=1 00000000", rv1, dout1);
        end
        idle(3);
    endtask

    task automatic test_inflight_drop();
        op(1, 4'hF, 4'd1, 32'h77777777, 0, '0);
        op(0, '0, '0, '0, 1, 4'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (rv2 !== 1'b0) begin
            fails++;
            $display("FAIL inflight_drop: got rv=%b expected 0", rv2);
        end
        step();
        rst = 1'b0;
        count_busy("clear_after_drop");
    endtask

    task automatic test_mid_clear_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("clear_restart");
        step();
        for (int a = 0; a < DEPTH; a += 5) op(0, '0, '0, '0, 1, AW'(a));
        idle(3);
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_byte_write();
        test_collision();
        test_bypass_window();
        test_back_to_back();
        test_random();
        test_busy_ignore();
        test_inflight_drop();
        test_mid_clear_reset();
        tests++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending reads expected 0/0", q1.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
